ald_pulse_sequencer: RTL and testbench

Downstream valve-timing stage of the ALD ladder-logic controller. The scan engine issues a start command once the precursor and purge presets are loaded. This block then runs the ALD recipe: for each cycle, and for each precursor in turn, it pulses that precursor valve, waits, then vacuum-purges. It drives the sv*/svac valve outputs and reports busy/done/cycle progress back to the scan engine, timing everything off the shared 1 kHz tick.

---
 rtl/ald_pkg.sv | 29 ++
 rtl/ald_pulse_sequencer_if.sv | 42 ++++
 rtl/ald_phase_timer.sv | 28 ++
 rtl/ald_pulse_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_ald_pulse_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ald_pkg.sv
// Shared types and helpers for the ALD pulse sequencer: FSM state encoding
// and per-precursor preset extraction from flattened preset buses.
package ald_pkg;

  localparam int unsigned MAX_PREC = 4;
  localparam int unsigned MAX_TW   = 64;
  localparam int unsigned BUS_W    = MAX_PREC * MAX_TW;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    WAIT,
    PURGE,
    ADV,
    FINISH
  } ald_state_t;

  // Returns the tw-bit field of precursor p (p0 at the LSBs), zero-extended.
  function automatic logic [MAX_TW-1:0] prec_slice(input logic [BUS_W-1:0] bus,
                                                   input int unsigned   p,
                                                   input int unsigned   tw);
    logic [BUS_W-1:0]  shifted;
    logic [MAX_TW-1:0] mask;
    shifted = bus >> (p * tw);
    mask    = (tw >= MAX_TW) ? '1 : ((MAX_TW'(1) << tw) - MAX_TW'(1));
    return shifted[MAX_TW-1:0] & mask;
  endfunction

endpackage

// File: rtl/ald_pulse_sequencer_if.sv
// Scan-engine <-> valve sequencer signal bundle. The hold input exists only
// when ALD_SEQ_HOLD_EN is defined.
interface ald_pulse_sequencer_if #(
  parameter int NUM_PREC = 3,
  parameter int TW       = 32,
  parameter int CW       = 16
);
  logic                   tick;
  logic                   start;
  logic                   abort;
  logic [NUM_PREC*TW-1:0] ton;
  logic [NUM_PREC*TW-1:0] twait;
  logic [NUM_PREC*TW-1:0] tvac;
  logic [CW-1:0]          cycles;
`ifdef ALD_SEQ_HOLD_EN
  logic                   hold;
`endif
  logic [NUM_PREC-1:0]    sv;
  logic                   svac;
  logic                   busy;
  logic                   done;
  logic                   aborted;
  logic [CW-1:0]          cycle_cnt;
  logic [1:0]             prec_idx;

  modport master (
    output tick, start, abort, ton, twait, tvac, cycles,
`ifdef ALD_SEQ_HOLD_EN
    output hold,
`endif
    input  sv, svac, busy, done, aborted, cycle_cnt, prec_idx
  );

  modport slave (
    input  tick, start, abort, ton, twait, tvac, cycles,
`ifdef ALD_SEQ_HOLD_EN
    input  hold,
`endif
    output sv, svac, busy, done, aborted, cycle_cnt, prec_idx
  );

endinterface

// File: rtl/ald_phase_timer.sv
// Phase timer shared by PULSE/WAIT/PURGE: counts ticks from clear and flags
// done once the count equals the preset (count then stops, so it never wraps).
module ald_phase_timer #(
  parameter int TW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          tick,
  input  logic [TW-1:0] preset,
  output logic          done
);

  logic [TW-1:0] acc_reg;

  assign done = (acc_reg == preset);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
    end else if (tick && !done) begin
      acc_reg <= acc_reg + TW'(1);
    end
  end

endmodule

// File: rtl/ald_pulse_sequencer.sv
// ALD valve sequencer: per cycle, per precursor runs PULSE -> WAIT -> PURGE.
// Optional ALD_SEQ_HOLD_EN adds a hold input that freezes the active phase.
module ald_pulse_sequencer #(
  parameter int NUM_PREC = 3,
  parameter int TW       = 32,
  parameter int CW       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ald_pulse_sequencer_if.slave  bus
);
  import ald_pkg::*;

  ald_state_t             state_reg, state_next;
  logic [NUM_PREC*TW-1:0] ton_reg, ton_next;
  logic [NUM_PREC*TW-1:0] twait_reg, twait_next;
  logic [NUM_PREC*TW-1:0] tvac_reg, tvac_next;
  logic [CW-1:0]          cycles_reg, cycles_next;
  logic [CW-1:0]          cycle_cnt_reg, cycle_cnt_next;
  logic [1:0]             prec_idx_reg, prec_idx_next;
  logic [NUM_PREC-1:0]    sv_reg, sv_next;
  logic                   svac_reg, svac_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic                   aborted_reg, aborted_next;

  logic                   hold_act;
  logic                   start_accept;
  logic                   phase_exit;
  logic                   timer_clear;
  logic                   timer_done;
  logic [TW-1:0]          phase_preset;

  logic [TW-1:0]          ton_arr   [MAX_PREC];
  logic [TW-1:0]          twait_arr [MAX_PREC];
  logic [TW-1:0]          tvac_arr  [MAX_PREC];
  logic [TW-1:0]          ton_nx_arr  [MAX_PREC];
  logic [TW-1:0]          tvac_nx_arr [MAX_PREC];

`ifdef ALD_SEQ_HOLD_EN
  assign hold_act = bus.hold;
`else
  assign hold_act = 1'b0;
`endif

  assign start_accept = (state_reg == IDLE) && bus.start && !bus.abort && !hold_act;
  assign phase_exit   = timer_done && !hold_act;

  // Shadow presets only move on an accepted start.
  assign ton_next    = start_accept ? bus.ton    : ton_reg;
  assign twait_next  = start_accept ? bus.twait  : twait_reg;
  assign tvac_next   = start_accept ? bus.tvac   : tvac_reg;
  assign cycles_next = start_accept ? bus.cycles : cycles_reg;

  generate
    for (genvar gi = 0; gi < MAX_PREC; gi++) begin : g_slice
      if (gi < NUM_PREC) begin : g_used
        assign ton_arr[gi]     = TW'(prec_slice(BUS_W'(ton_reg),   gi, TW));
        assign twait_arr[gi]   = TW'(prec_slice(BUS_W'(twait_reg), gi, TW));
        assign tvac_arr[gi]    = TW'(prec_slice(BUS_W'(tvac_reg),  gi, TW));
        assign ton_nx_arr[gi]  = TW'(prec_slice(BUS_W'(ton_next),  gi, TW));
        assign tvac_nx_arr[gi] = TW'(prec_slice(BUS_W'(tvac_next), gi, TW));
      end else begin : g_unused
        assign ton_arr[gi]     = '0;
        assign twait_arr[gi]   = '0;
        assign tvac_arr[gi]    = '0;
        assign ton_nx_arr[gi]  = '0;
        assign tvac_nx_arr[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    phase_preset = '0;
    case (state_reg)
      PULSE:   phase_preset = ton_arr[prec_idx_reg];
      WAIT:    phase_preset = twait_arr[prec_idx_reg];
      PURGE:   phase_preset = tvac_arr[prec_idx_reg];
      default: phase_preset = '0;
    endcase
  end

  ald_phase_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .tick   (bus.tick && !hold_act),
    .preset (phase_preset),
    .done   (timer_done)
  );

  always_comb begin
    state_next     = state_reg;
    prec_idx_next  = prec_idx_reg;
    cycle_cnt_next = cycle_cnt_reg;
    timer_clear    = 1'b1;
    done_next      = 1'b0;
    aborted_next   = 1'b0;
    sv_next        = '0;
    svac_next      = 1'b0;
    busy_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_accept) begin
          cycle_cnt_next = '0;
          prec_idx_next  = '0;
          state_next     = (bus.cycles == '0) ? FINISH : PULSE;
        end
      end
      PULSE, WAIT, PURGE: begin
        // Clearing on exit also drops a tick that lands on the exit clock.
        timer_clear = phase_exit;
        if (phase_exit) begin
          state_next = (state_reg == PULSE) ? WAIT :
                       (state_reg == WAIT)  ? PURGE : ADV;
        end
      end
      ADV: begin
        if (prec_idx_reg < 2'(NUM_PREC - 1)) begin
          prec_idx_next = prec_idx_reg + 2'd1;
          state_next    = PULSE;
        end else begin
          prec_idx_next  = '0;
          cycle_cnt_next = cycle_cnt_reg + CW'(1);
          state_next     = (cycle_cnt_next == cycles_reg) ? FINISH : PULSE;
        end
      end
      FINISH: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (bus.abort && (state_reg != IDLE)) begin
      state_next   = IDLE;
      aborted_next = 1'b1;
      done_next    = 1'b0;
      timer_clear  = 1'b1;
    end

    // Outputs are decoded from the next state so they line up with the state register.
    busy_next = (state_next != IDLE);
    if (!hold_act) begin
      if ((state_next == PULSE) && (ton_nx_arr[prec_idx_next] != '0)) begin
        sv_next = NUM_PREC'(1) << prec_idx_next;
      end
      if ((state_next == PURGE) && (tvac_nx_arr[prec_idx_next] != '0)) begin
        svac_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      ton_reg       <= '0;
      twait_reg     <= '0;
      tvac_reg      <= '0;
      cycles_reg    <= '0;
      cycle_cnt_reg <= '0;
      prec_idx_reg  <= '0;
      sv_reg        <= '0;
      svac_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      aborted_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ton_reg       <= ton_next;
      twait_reg     <= twait_next;
      tvac_reg      <= tvac_next;
      cycles_reg    <= cycles_next;
      cycle_cnt_reg <= cycle_cnt_next;
      prec_idx_reg  <= prec_idx_next;
      sv_reg        <= sv_next;
      svac_reg      <= svac_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      aborted_reg   <= aborted_next;
    end
  end

  assign bus.sv        = sv_reg;
  assign bus.svac      = svac_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.aborted   = aborted_reg;
  assign bus.cycle_cnt = cycle_cnt_reg;
  assign bus.prec_idx  = prec_idx_reg;

endmodule

// File: tb/tb_ald_pulse_sequencer.sv
// Scoreboard bench for ald_pulse_sequencer; directed runs push expected run
// summaries, a monitor checks them on each done/aborted pulse.
`timescale 1ns/1ps
module tb_ald_pulse_sequencer;

  localparam int NUM_PREC = 3;
  localparam int TW       = 32;
  localparam int CW       = 4;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  typedef struct {
    bit is_abort;
    int cnt;
    int sv0;
    int sv1;
    int sv2;
    int svac_t;
    int busy_t;
    int sv_clks;
    int lat;
  } exp_t;

  exp_t expq[$];

  ald_pulse_sequencer_if #(.NUM_PREC(NUM_PREC), .TW(TW), .CW(CW)) bus ();

  ald_pulse_sequencer #(.NUM_PREC(NUM_PREC), .TW(TW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 1 kHz tick stand-in: one clock high every 4 clocks.
  initial begin
    int div;
    div = 0;
    bus.tick = 1'b0;
    forever begin
      @(negedge clk);
      div = (div == 3) ? 0 : div + 1;
      bus.tick = (div == 0);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    if (exp < 0) return;
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_push(input bit a, input int cnt, input int s0, input int s1, input int s2,
                          input int sva, input int bt, input int svc, input int lat);
    exp_t e;
    e.is_abort = a; e.cnt = cnt; e.sv0 = s0; e.sv1 = s1; e.sv2 = s2;
    e.svac_t = sva; e.busy_t = bt; e.sv_clks = svc; e.lat = lat;
    expq.push_back(e);
  endtask

  // Monitor: accumulates per-run observations, checks against the queue head.
  int     mon_sv_t [NUM_PREC];
  int     mon_svac_t, mon_busy_t, mon_sv_clks, mon_inv;
  longint mon_rise;
  bit     mon_busy_prev, mon_done_prev;

  initial begin
    exp_t e;
    for (int i = 0; i < NUM_PREC; i++) mon_sv_t[i] = 0;
    mon_svac_t = 0; mon_busy_t = 0; mon_sv_clks = 0; mon_inv = 0;
    mon_rise = 0; mon_busy_prev = 0; mon_done_prev = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        if ($countones(bus.sv) > 1) mon_inv++;
        if (bus.svac && (|bus.sv)) mon_inv++;
        if (!bus.busy && (bus.svac || (|bus.sv))) mon_inv++;
        if (bus.done && (bus.aborted || mon_done_prev)) mon_inv++;
        if (bus.busy && !mon_busy_prev) mon_rise = cyc;
        if (bus.tick) begin
          for (int i = 0; i < NUM_PREC; i++) if (bus.sv[i]) mon_sv_t[i]++;
          if (bus.svac) mon_svac_t++;
          if (bus.busy) mon_busy_t++;
        end
        if (|bus.sv) mon_sv_clks++;
        if (bus.done || bus.aborted) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_end: got done=%0b aborted=%0b, expected no completion",
                     bus.done, bus.aborted);
          end else begin
            e = expq.pop_front();
            $display("[%0t] run end: aborted=%0b cycle_cnt=%0d sv_ticks=%0d/%0d/%0d svac_ticks=%0d busy_ticks=%0d",
                     $time, bus.aborted, bus.cycle_cnt, mon_sv_t[0], mon_sv_t[1], mon_sv_t[2],
                     mon_svac_t, mon_busy_t);
            chk("end_kind_aborted", bus.aborted, e.is_abort);
            chk("cycle_cnt", bus.cycle_cnt, e.cnt);
            chk("sv0_ticks", mon_sv_t[0], e.sv0);
            chk("sv1_ticks", mon_sv_t[1], e.sv1);
            chk("sv2_ticks", mon_sv_t[2], e.sv2);
            chk("svac_ticks", mon_svac_t, e.svac_t);
            chk("busy_ticks", mon_busy_t, e.busy_t);
            chk("sv_clks", mon_sv_clks, e.sv_clks);
            chk("latency", cyc - mon_rise, e.lat);
            chk("busy_at_end", bus.busy, 0);
            chk("valves_at_end", {bus.svac, bus.sv}, 0);
            chk("invariants", mon_inv, 0);
          end
          for (int i = 0; i < NUM_PREC; i++) mon_sv_t[i] = 0;
          mon_svac_t = 0; mon_busy_t = 0; mon_sv_clks = 0; mon_inv = 0;
        end
        mon_busy_prev = bus.busy;
        mon_done_prev = bus.done;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int t0, input int t1, input int t2, input int w, input int v, input int c);
    bus.ton    = {TW'(t2), TW'(t1), TW'(t0)};
    bus.twait  = {TW'(w), TW'(w), TW'(w)};
    bus.tvac   = {TW'(v), TW'(v), TW'(v)};
    bus.cycles = CW'(c);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_busy(input bit lvl, input int budget, input string what);
    int n;
    n = 0;
    while (bus.busy !== lvl && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (bus.busy !== lvl) begin
      errors++;
      $display("FAIL %s: busy=%0b after %0d clk, expected %0b", what, bus.busy, n, lvl);
    end
  endtask

  task automatic run_to_end(input string what);
    pulse_start();
    wait_busy(1'b1, 8, {what, "_begin"});
    wait_busy(1'b0, 3000, {what, "_end"});
    step(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.start = 1'b1;
    bus.abort = 1'b0;
`ifdef ALD_SEQ_HOLD_EN
    bus.hold = 1'b0;
`endif
    load(2, 3, 4, 1, 5, 2);
    step(3);
    #1;
    chk("reset_outputs", {bus.cycle_cnt, bus.prec_idx, bus.aborted, bus.done, bus.busy, bus.svac, bus.sv}, 0);
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    step(4);

    $display("[%0t] run: nominal recipe, 2 cycles", $time);
    exp_push(0, 2, 4, 6, 8, 30, 54, -1, -1);
    run_to_end("nominal");
    chk("cycle_cnt_hold", bus.cycle_cnt, 2);
    chk("prec_idx_after", bus.prec_idx, 0);

    $display("[%0t] run: cycles=0", $time);
    load(2, 3, 4, 1, 5, 0);
    exp_push(0, 0, 0, 0, 0, 0, -1, 0, 1);
    run_to_end("zero_cycles");

    $display("[%0t] run: zero pulse presets", $time);
    load(0, 0, 0, 0, 1, 1);
    exp_push(0, 1, 0, 0, 0, 3, -1, 0, -1);
    run_to_end("zero_presets");

    $display("[%0t] run: abort during precursor 1 pulse", $time);
    load(2, 3, 4, 1, 5, 2);
    exp_push(1, 0, 2, -1, 0, 5, -1, -1, -1);
    pulse_start();
    n = 0;
    while (!bus.sv[1] && n < 2000) begin @(negedge clk); #1; n++; end
    chk("sv1_reached", bus.sv[1], 1);
    step(2);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    #1;
    chk("abort_busy_low", bus.busy, 0);
    step(3);

    $display("[%0t] stim: abort and start together in IDLE", $time);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step(1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    step(3);
    #1;
    chk("idle_abort_start_busy", bus.busy, 0);

    $display("[%0t] run: restart after abort", $time);
    exp_push(0, 2, 4, 6, 8, 30, 54, -1, -1);
    run_to_end("restart");

    $display("[%0t] run: presets changed and start re-pulsed mid-run", $time);
    exp_push(0, 2, 4, 6, 8, 30, 54, -1, -1);
    pulse_start();
    wait_busy(1'b1, 8, "latched_begin");
    step(20);
    load(7, 7, 7, 7, 7, 1);
    bus.start = 1'b1;
    step(2);
    bus.start = 1'b0;
    wait_busy(1'b0, 3000, "latched_end");
    step(6);
    chk("latched_single_done_busy", bus.busy, 0);

    $display("[%0t] run: cycles=2^CW-1 with zero presets", $time);
    load(0, 0, 0, 0, 0, 15);
    exp_push(0, 15, 0, 0, 0, 0, -1, 0, 181);
    run_to_end("max_cycles");
    chk("max_cycles_cnt_hold", bus.cycle_cnt, 15);

`ifdef ALD_SEQ_HOLD_EN
    begin
      int k, hticks, svac_during, rem;
      $display("[%0t] run: hold during purge", $time);
      load(2, 3, 4, 1, 5, 1);
      exp_push(0, 1, 2, 3, 4, 15, 37, -1, -1);
      pulse_start();
      #1;
      k = 0; n = 0;
      while (k < 2 && n < 500) begin
        if (bus.tick && bus.svac) k++;
        if (k < 2) begin @(negedge clk); #1; n++; end
      end
      chk("hold_reach_acc2", k, 2);
      @(negedge clk);
      bus.hold = 1'b1;
      hticks = 0; svac_during = 0; n = 0;
      while (hticks < 10 && n < 500) begin
        @(negedge clk); #1; n++;
        if (bus.tick) begin
          hticks++;
          if (bus.svac) svac_during++;
        end
      end
      @(negedge clk);
      bus.hold = 1'b0;
      chk("hold_svac_low", svac_during, 0);
      n = 0;
      while (!bus.svac && n < 20) begin @(negedge clk); #1; n++; end
      rem = 0; n = 0;
      while (bus.svac && n < 500) begin
        if (bus.tick) rem++;
        @(negedge clk); #1; n++;
      end
      chk("hold_remaining_ticks", rem, 3);
      wait_busy(1'b0, 3000, "hold_end");
      step(3);
    end
`endif

    step(5);
    chk("pending_expectations", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
